// File: rtl/bnn_layer_engine.sv
// bnn_layer_engine: binarized fully-connected layer datapath.
// Latches one activation vector, then accepts one weight row plus bias per
// beat and writes each neuron's sign(2*popcount(xnor) - IN_WIDTH + bias)
// into a packed output vector through a 2-stage pipeline.
module bnn_layer_engine #(
    parameter int unsigned IN_WIDTH    = 512,
    parameter int unsigned NUM_NEURONS = 1024,
    parameter int unsigned BIAS_WIDTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   act_valid,
    input  logic [IN_WIDTH-1:0]    act_in,
    input  logic                   w_valid,
    input  logic [IN_WIDTH-1:0]    w_data,
    input  logic [BIAS_WIDTH-1:0]  b_data,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_NEURONS-1:0] out_vec
);

    localparam int unsigned PCW = $clog2(IN_WIDTH + 1);
    localparam int unsigned SW  = PCW + 2;
    localparam int unsigned IW  = $clog2(NUM_NEURONS + 1);
    localparam int unsigned TW  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

    localparam logic [IW-1:0]        N_IDX    = IW'(NUM_NEURONS);
    localparam logic [IW-1:0]        LAST_IDX = IW'(NUM_NEURONS - 1);
    localparam logic [TW-1:0]        LAST_TAG = TW'(NUM_NEURONS - 1);
    localparam logic signed [SW-1:0] IN_W_S   = SW'(IN_WIDTH);
    localparam logic signed [SW-1:0] ZERO_S   = '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [IN_WIDTH-1:0]    act_q, act_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [NUM_NEURONS-1:0] out_q, out_d;

    // Stage 1 registers: popcount, bias and neuron tag of an accepted beat.
    logic                   s1_valid_q;
    logic [PCW-1:0]         s1_pc_q;
    logic [BIAS_WIDTH-1:0]  s1_bias_q;
    logic [TW-1:0]          s1_tag_q;
    // Set the cycle after the final neuron's bit lands in out_q.
    logic                   wb_last_q;

    logic                   start;
    logic                   accept;
    logic [PCW-1:0]         pc_d;
    logic signed [SW-1:0]   sum;
    logic                   res_bit;

    // Next-state logic: pass sequencing, activation latch and beat index.
    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        idx_d   = idx_q;
        start   = 1'b0;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (act_valid) begin
                    start   = 1'b1;
                    act_d   = act_in;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (w_valid && (idx_q < N_IDX)) begin
                    accept = 1'b1;
                    idx_d  = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (wb_last_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Stage 1 combinational: XNOR of activations and weights, then popcount.
    always_comb begin
        pc_d = '0;
        for (int unsigned i = 0; i < IN_WIDTH; i++) begin
            pc_d = pc_d + PCW'(~(act_q[i] ^ w_data[i]));
        end
    end

    // Stage 2 combinational: signed sum and its sign bit (zero counts as +1).
    always_comb begin
        sum = $signed({1'b0, s1_pc_q, 1'b0}) - IN_W_S
            + $signed({{(SW - BIAS_WIDTH){s1_bias_q[BIAS_WIDTH-1]}}, s1_bias_q});
        res_bit = (sum >= ZERO_S);
    end

    // Output vector update: cleared on pass start, one bit written per result.
    always_comb begin
        out_d = out_q;
        if (start) begin
            out_d = '0;
        end else if (s1_valid_q) begin
            out_d[s1_tag_q] = res_bit;
        end
    end

    // State, index, activation latch and pipeline registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            act_q      <= '0;
            idx_q      <= '0;
            out_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_pc_q    <= '0;
            s1_bias_q  <= '0;
            s1_tag_q   <= '0;
            wb_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            act_q      <= act_d;
            idx_q      <= idx_d;
            out_q      <= out_d;
            s1_valid_q <= accept;
            if (accept) begin
                s1_pc_q   <= pc_d;
                s1_bias_q <= b_data;
                s1_tag_q  <= idx_q[TW-1:0];
            end
            wb_last_q  <= s1_valid_q && (s1_tag_q == LAST_TAG);
        end
    end

    assign busy    = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done    = (state_q == S_DONE);
    assign out_vec = out_q;

endmodule

// File: tb/tb_bnn_layer_engine.sv
// Testbench for bnn_layer_engine: a small 8x4 instance driven from a vector
// table plus directed corner sequences, and a default 512x1024 instance
// driven with random data checked against an arithmetic reference model.
module tb_bnn_layer_engine;

    logic clk;
    logic rst;

    // Small instance (IN_WIDTH=8, NUM_NEURONS=4)
    logic       s_act_valid;
    logic [7:0] s_act_in;
    logic       s_w_valid;
    logic [7:0] s_w_data;
    logic [1:0] s_b_data;
    logic       s_busy;
    logic       s_done;
    logic [3:0] s_out_vec;

    // Default instance (IN_WIDTH=512, NUM_NEURONS=1024)
    logic          l_act_valid;
    logic [511:0]  l_act_in;
    logic          l_w_valid;
    logic [511:0]  l_w_data;
    logic [1:0]    l_b_data;
    logic          l_busy;
    logic          l_done;
    logic [1023:0] l_out_vec;

    int checks = 0;
    int errors = 0;

    bnn_layer_engine #(
        .IN_WIDTH   (8),
        .NUM_NEURONS(4),
        .BIAS_WIDTH (2)
    ) dut_s (
        .clk      (clk),
        .rst      (rst),
        .act_valid(s_act_valid),
        .act_in   (s_act_in),
        .w_valid  (s_w_valid),
        .w_data   (s_w_data),
        .b_data   (s_b_data),
        .busy     (s_busy),
        .done     (s_done),
        .out_vec  (s_out_vec)
    );

    bnn_layer_engine dut_l (
        .clk      (clk),
        .rst      (rst),
        .act_valid(l_act_valid),
        .act_in   (l_act_in),
        .w_valid  (l_w_valid),
        .w_data   (l_w_data),
        .b_data   (l_b_data),
        .busy     (l_busy),
        .done     (l_done),
        .out_vec  (l_out_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [7:0]      act;
        logic [3:0][7:0] w;
        logic [3:0][1:0] b;
        int              gap;
        int              extra;
        bit              poke;
        logic [3:0]      exp;
    } svec_t;

    svec_t tbl[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Sign of (2*matches - width + bias), computed directly from the rule.
    function automatic bit ref_bit(input logic [511:0] a, input logic [511:0] w,
                                   input int width, input logic [1:0] b);
        int pc;
        int bi;
        int s;
        pc = 0;
        for (int j = 0; j < width; j++) begin
            if (a[j] == w[j]) pc++;
        end
        bi = b[1] ? int'(b) - 4 : int'(b);
        s  = 2 * pc - width + bi;
        return (s >= 0);
    endfunction

    task automatic wait_done_small(output int cnt);
        cnt = 0;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (s_done) cnt++;
        end
    endtask

    task automatic run_small(input svec_t v, input string name);
        bit busy_ok;
        bit busy_at_done;
        int done_cnt;
        int done_lat;
        int lat;
        s_act_in    = v.act;
        s_act_valid = 1'b1;
        tick();
        s_act_valid = 1'b0;
        busy_ok = s_busy;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                for (int g = 0; g < v.gap; g++) begin
                    tick();
                    busy_ok = busy_ok && s_busy;
                end
            end
            s_w_valid = 1'b1;
            s_w_data  = v.w[k];
            s_b_data  = v.b[k];
            if (k < 3) begin
                tick();
                busy_ok   = busy_ok && s_busy;
                s_w_valid = 1'b0;
            end
        end
        done_cnt     = 0;
        done_lat     = -1;
        busy_at_done = 1'b1;
        lat          = 0;
        while (lat < 20) begin
            tick();
            lat++;
            if (s_done) begin
                done_cnt++;
                if (done_lat < 0) begin
                    done_lat     = lat;
                    busy_at_done = s_busy;
                end
            end else if (done_cnt == 0) begin
                busy_ok = busy_ok && s_busy;
            end
            if (lat <= v.extra) begin
                s_w_valid = 1'b1;
                s_w_data  = 8'($urandom());
                s_b_data  = 2'($urandom());
            end else begin
                s_w_valid = 1'b0;
            end
            s_act_valid = v.poke && s_done;
            s_act_in    = ~v.act;
        end
        s_act_valid = 1'b0;
        check_int({name, " busy during pass"}, int'(busy_ok), 1);
        check_int({name, " done latency"}, done_lat, 3);
        check_int({name, " done count"}, done_cnt, 1);
        check_int({name, " busy with done"}, int'(busy_at_done), 0);
        check_int({name, " out_vec"}, int'(s_out_vec), int'(v.exp));
        check_int({name, " busy after"}, int'(s_busy), 0);
    endtask

    task automatic run_large(input int pass);
        logic [511:0]  a;
        logic [511:0]  w;
        logic [1:0]    b;
        logic [1023:0] exp;
        bit            busy_ok;
        int            done_cnt;
        int            nbad;
        for (int k = 0; k < 16; k++) a[k*32 +: 32] = $urandom();
        l_act_in    = a;
        l_act_valid = 1'b1;
        tick();
        l_act_valid = 1'b0;
        busy_ok = l_busy;
        for (int n = 0; n < 1024; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                l_w_valid = 1'b0;
                tick();
                busy_ok = busy_ok && l_busy && !l_done;
            end
            for (int k = 0; k < 16; k++) w[k*32 +: 32] = $urandom();
            b      = 2'($urandom());
            exp[n] = ref_bit(a, w, 512, b);
            l_w_valid = 1'b1;
            l_w_data  = w;
            l_b_data  = b;
            tick();
            busy_ok = busy_ok && l_busy && !l_done;
        end
        l_w_valid = 1'b0;
        done_cnt  = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (l_done) done_cnt++;
            else if (done_cnt == 0) busy_ok = busy_ok && l_busy;
        end
        nbad = 0;
        for (int i = 0; i < 1024; i++) begin
            if (l_out_vec[i] !== exp[i]) nbad++;
        end
        check_int($sformatf("large%0d busy during pass", pass), int'(busy_ok), 1);
        check_int($sformatf("large%0d done count", pass), done_cnt, 1);
        check_int($sformatf("large%0d out_vec bad bits", pass), nbad, 0);
        check_int($sformatf("large%0d busy after", pass), int'(l_busy), 0);
    endtask

    initial begin
        int    cnt;
        svec_t rv;

        tbl[0].act = 8'hFF;
        tbl[0].w   = {8'h0F, 8'h0F, 8'h00, 8'hFF};
        tbl[0].b   = {2'b11, 2'b00, 2'b00, 2'b00};
        tbl[0].gap = 0; tbl[0].extra = 0; tbl[0].poke = 1'b0;
        tbl[0].exp = 4'b0101;

        tbl[1]       = tbl[0];
        tbl[1].gap   = 2;
        tbl[1].extra = 2;

        tbl[2].act = 8'hAA;
        tbl[2].w   = {8'h55, 8'hAA, 8'hAA, 8'h55};
        tbl[2].b   = {2'b11, 2'b00, 2'b10, 2'b01};
        tbl[2].gap = 1; tbl[2].extra = 1; tbl[2].poke = 1'b0;
        tbl[2].exp = 4'b0110;

        tbl[3].act = 8'h3C;
        tbl[3].w   = {8'h3D, 8'h0F, 8'hC3, 8'h3C};
        tbl[3].b   = {2'b11, 2'b00, 2'b01, 2'b10};
        tbl[3].gap = 0; tbl[3].extra = 2; tbl[3].poke = 1'b1;
        tbl[3].exp = 4'b1101;

        rst         = 1'b0;
        s_act_valid = 1'b0; s_act_in = '0; s_w_valid = 1'b0; s_w_data = '0; s_b_data = '0;
        l_act_valid = 1'b0; l_act_in = '0; l_w_valid = 1'b0; l_w_data = '0; l_b_data = '0;
        tick(); tick(); tick();
        check_int("reset small busy", int'(s_busy), 0);
        check_int("reset small done", int'(s_done), 0);
        check_int("reset small out_vec", int'(s_out_vec), 0);
        check_int("reset large busy", int'(l_busy), 0);
        check_int("reset large out_vec nonzero", int'(l_out_vec != '0), 0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            run_small(tbl[i], $sformatf("tbl%0d", i));
            tick();
        end

        // Beats while idle, then an act_valid re-pulse mid-pass.
        s_w_valid = 1'b1; s_w_data = 8'h00; s_b_data = 2'b00;
        tick(); tick(); tick();
        s_w_valid = 1'b0;
        check_int("idle beats out_vec held", int'(s_out_vec), 4'b1101);
        check_int("idle beats busy", int'(s_busy), 0);
        s_act_in = 8'hFF; s_act_valid = 1'b1;
        tick();
        s_act_valid = 1'b0;
        s_w_valid = 1'b1; s_w_data = 8'hFF; s_b_data = 2'b00; tick();
        s_w_data = 8'h00; s_b_data = 2'b00; tick();
        s_w_valid = 1'b0; s_act_in = 8'h0F; s_act_valid = 1'b1; tick();
        s_act_valid = 1'b0;
        check_int("repulse busy", int'(s_busy), 1);
        s_w_valid = 1'b1; s_w_data = 8'h0F; s_b_data = 2'b00; tick();
        s_w_data = 8'h0F; s_b_data = 2'b11; tick();
        s_w_valid = 1'b0;
        wait_done_small(cnt);
        check_int("repulse done count", cnt, 1);
        check_int("repulse out_vec", int'(s_out_vec), 4'b0101);

        // Reset in the middle of a pass.
        s_act_in = 8'hFF; s_act_valid = 1'b1; tick();
        s_act_valid = 1'b0;
        s_w_valid = 1'b1; s_w_data = 8'hFF; s_b_data = 2'b00; tick();
        s_w_data = 8'h00; tick();
        s_w_valid = 1'b0; rst = 1'b0; tick();
        rst = 1'b1;
        check_int("midreset out_vec", int'(s_out_vec), 0);
        check_int("midreset busy", int'(s_busy), 0);
        s_w_valid = 1'b1; s_w_data = 8'h0F; s_b_data = 2'b00; tick(); tick();
        s_w_valid = 1'b0;
        wait_done_small(cnt);
        check_int("midreset no done", cnt, 0);
        check_int("midreset out_vec after", int'(s_out_vec), 0);
        run_small(tbl[0], "after_reset");
        tick();

        // Random small passes against the reference model.
        for (int p = 0; p < 4; p++) begin
            rv.act = 8'($urandom());
            for (int k = 0; k < 4; k++) begin
                rv.w[k]   = 8'($urandom());
                rv.b[k]   = 2'($urandom());
                rv.exp[k] = ref_bit(512'(rv.act), 512'(rv.w[k]), 8, rv.b[k]);
            end
            rv.gap   = $urandom_range(0, 2);
            rv.extra = $urandom_range(0, 2);
            rv.poke  = 1'b0;
            run_small(rv, $sformatf("rand%0d", p));
            tick();
        end

        for (int p = 0; p < 2; p++) begin
            run_large(p);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bnn_layer_engine.md
Name: bnn_layer_engine

Overview:
Binarized fully-connected layer datapath that sits directly downstream of the layer controller. It latches one binary activation vector. It then consumes one weight row plus bias per beat from the controller's weight and bias outputs. For each neuron it computes XNOR-popcount plus bias and the sign bit, and packs the results into an output activation vector. When the layer completes, it pulses done, which drives the controller's valid_1 or valid_2 for the next layer.

Parameters:
IN_WIDTH, 512, activation vector width and weight row width (bits)
NUM_NEURONS, 1024, neurons in this layer (output vector width)
BIAS_WIDTH, 2, bias width, two's complement signed

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-low
act_valid  input  1  one-cycle pulse: latch act_in and start a layer pass
act_in  input  IN_WIDTH  binary input activations (1 = +1, 0 = -1)
w_valid  input  1  weight and bias beat valid
w_data  input  IN_WIDTH  weight row for the current neuron
b_data  input  BIAS_WIDTH  signed bias for the current neuron
busy  output  1  high from the accepted act_valid until done
done  output  1  one-cycle pulse when all NUM_NEURONS results are written
out_vec  output  NUM_NEURONS  packed output activations; bit i is neuron i

Behaviour:
- Reset (rst=0 at posedge clk): state=IDLE, busy=0, done=0, out_vec=0, neuron index=0, pipeline valids=0. Reset mid-pass aborts the pass immediately; the next pass needs a new act_valid.

State machine:
- IDLE: act_valid=1 latches act_in, sets index=0, clears out_vec, moves to RUN; busy=1 from the next cycle. w_valid is ignored in IDLE.
- RUN: each cycle with w_valid=1 and index<NUM_NEURONS accepts a beat and increments index. When index reaches NUM_NEURONS the state moves to DRAIN. act_valid is ignored in RUN.
- DRAIN: waits for the pipeline to empty. Extra w_valid beats are ignored; the controller overshoots by up to 2 beats. When the last result is written, the state moves to DONE.
- DONE: done=1 for exactly one cycle, busy=0 in that same cycle, then the state returns to IDLE.

Datapath (2-stage pipeline):
- Stage 1 (registered): xnor = ~(act_reg ^ w_data); pc = popcount(xnor), width $clog2(IN_WIDTH+1). The bias is registered alongside pc, and the index is tagged.
- Stage 2 (registered): sum = 2*pc - IN_WIDTH + sign_extend(bias), computed signed at width $clog2(IN_WIDTH+1)+2. No overflow is possible at this width. The result bit is 1 if sum >= 0, else 0; a tie at 0 gives 1. out_vec[tag] is set to this bit.
- Latency: out_vec[i] is updated 2 cycles after beat i is accepted. done is asserted the cycle after the write of bit NUM_NEURONS-1.
- Beats may be non-contiguous: gaps in w_valid stall the index, and bubbles flow through the pipeline.
- out_vec holds its value after done until the next accepted act_valid. act_valid in the same cycle as done is ignored.

Test Plan:
1. IN_WIDTH=8, NUM_NEURONS=4, act_in=8'hFF, w_data=FF,00,0F,0F with b_data=0,0,0,2'b11 on 4 contiguous beats -> sums 8, -8, 0, -1; out_vec=4'b0101; done pulses 1 cycle after bit 3 is written (exactly 3 cycles after the last beat).
2. Same configuration with beats separated by 2 idle cycles, then 2 extra trailing w_valid beats -> identical out_vec=4'b0101, extra beats ignored, exactly one done pulse.
3. w_valid beats before act_valid, and act_valid re-pulsed mid-RUN with a different act_in -> pre-start beats ignored; the result uses the first latched activations only.
4. rst=0 asserted after 2 beats -> out_vec=0, busy=0, done never fires; a fresh act_valid then a full pass gives the correct result.
5. IN_WIDTH=8, act_in=8'hAA, w_data=8'h55, b_data=2'b01 -> pc=0, sum=-7, bit=0. Then w_data=8'hAA, b_data=2'b10 (-2) -> sum=6, bit=1.
6. Default parameters (512/1024), random vectors vs. a reference model -> all 1024 bits match; done occurs exactly once; busy is high for the full pass.
